// File: rtl/ambtc_pkg.sv
// Shared types and helpers for the grayscale / AMBTC image engine.
// Widths are functions of the engine parameters so each instance derives its own.
package ambtc_pkg;

  typedef enum logic [3:0] {
    IDLE, G_ADDR, G_WR, B_SUM, B_MEAN, B_DEV, B_VAR, B_DLO, B_DHI, B_WR, B_NEXT, DONE
  } ambtc_state_e;

  localparam int GRAY_MAX_W = 16;

  // Block sum width; the deviation sum and P = N*var share it.
  function automatic int sum_w(input int pix_w, input int blk_log2);
    return pix_w + 2 * blk_log2;
  endfunction

  function automatic int p_w(input int pix_w, input int blk_log2);
    return sum_w(pix_w, blk_log2);
  endfunction

  function automatic int blk_n(input int blk_log2);
    return 1 << (2 * blk_log2);
  endfunction

  // (max + min) >> 1, with one guard bit so the sum cannot overflow.
  function automatic logic [GRAY_MAX_W-1:0] gray_of(input logic [GRAY_MAX_W-1:0] r,
                                                   input logic [GRAY_MAX_W-1:0] g,
                                                   input logic [GRAY_MAX_W-1:0] b);
    logic [GRAY_MAX_W-1:0] mx, mn;
    logic [GRAY_MAX_W:0] s;
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    s = {1'b0, mx} + {1'b0, mn};
    return s[GRAY_MAX_W:1];
  endfunction

endpackage

// File: rtl/ambtc_image_engine_div.sv
// Restoring unsigned divider: quotient valid with a one-cycle done pulse
// exactly W cycles after start. Divisor must be non-zero.
module seq_div_u #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CNT_W = $clog2(W);

  logic [W-1:0]     rem, dsr;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [W:0]       trial;

  // The dividend shifts out of the quotient register MSB-first as quotient bits shift in.
  assign trial = {rem, quotient[W-1]} - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem      <= '0;
      dsr      <= '0;
      quotient <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        dsr      <= divisor;
        quotient <= dividend;
        cnt      <= '0;
        run      <= 1'b1;
      end else if (run) begin
        if (!trial[W]) begin
          rem      <= trial[W-1:0];
          quotient <= {quotient[W-2:0], 1'b1};
        end else begin
          rem      <= {rem[W-2:0], quotient[W-1]};
          quotient <= {quotient[W-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(W - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/ambtc_image_engine.sv
// Grayscale rewrite of a square image in external RAM, optionally followed by
// per-block AMBTC compress-and-reconstruct. FSM state is exported on dbg_state.
module ambtc_image_engine
  import ambtc_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int BLK_LOG2 = 2,
  parameter int PIX_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode_compress,
  input  logic [3*PIX_W-1:0]   in_pix,
  output logic [ADDR_W-1:0]    row,
  output logic [ADDR_W-1:0]    col,
  output logic                 out_we,
  output logic [3*PIX_W-1:0]   out_pix,
  output logic                 busy,
  output logic                 gray_done,
  output logic                 compress_done,
  output ambtc_state_e         dbg_state
);
  localparam int SUM_W  = sum_w(PIX_W, BLK_LOG2);
  localparam int P_W    = p_w(PIX_W, BLK_LOG2);
  localparam int BLK_N  = blk_n(BLK_LOG2);
  localparam int IDX_W  = 2 * BLK_LOG2;
  localparam int BETA_W = IDX_W + 1;
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  ambtc_state_e state, state_d;
  logic ph, ph_d, mode_q, we_c, div_start, div_done;
  logic [P_W-1:0]   div_q, div_dsr;
  logic [P_W:0]     hm_sum;
  logic [SUM_W-1:0] sum, dev, p_val;
  logic [PIX_W-1:0] avg, lm, hm, g_in, g_gray, abs_d;
  logic [BETA_W-1:0] beta, lo_cnt;
  logic [BLK_N-1:0] bitmap;
  logic [IDX_W-1:0] idx;
  logic last_pix, last_in_blk, last_blk, hit;

  assign idx         = {row[BLK_LOG2-1:0], col[BLK_LOG2-1:0]};
  assign last_pix    = &{row, col};
  assign last_in_blk = &idx;
  assign last_blk    = &{row[ADDR_W-1:BLK_LOG2], col[ADDR_W-1:BLK_LOG2]};
  assign g_in        = in_pix[2*PIX_W-1:PIX_W];
  assign g_gray      = PIX_W'(gray_of(GRAY_MAX_W'(in_pix[3*PIX_W-1:2*PIX_W]),
                                      GRAY_MAX_W'(g_in), GRAY_MAX_W'(in_pix[PIX_W-1:0])));
  assign hit         = (g_in >= avg);
  assign abs_d       = hit ? (g_in - avg) : (avg - g_in);
  assign lo_cnt      = BETA_W'(BLK_N) - beta;
  assign div_dsr     = (state == B_DLO) ? P_W'({lo_cnt, 1'b0}) : P_W'({beta, 1'b0});
  assign hm_sum      = {1'b0, P_W'(avg)} + {1'b0, div_q};
  assign dbg_state   = state;
  assign out_we      = we_c & rst_n;

  seq_div_u #(.W(P_W)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (p_val),
    .divisor  (div_dsr),
    .quotient (div_q),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ph    <= 1'b0;
    end else begin
      state <= state_d;
      ph    <= ph_d;
    end
  end

  // Handshake: start is a request honoured only in IDLE; busy is the
  // acknowledge and stays high until the pass requested by mode_compress ends.
  // Sweep states use ph: 0 = address cycle, 1 = data/write cycle.
  always_comb begin
    state_d   = state;
    ph_d      = ph;
    we_c      = 1'b0;
    div_start = 1'b0;
    case (state)
      IDLE:   if (start) begin state_d = G_ADDR; ph_d = 1'b0; end
      G_ADDR: state_d = G_WR;
      G_WR: begin
        we_c    = 1'b1;
        state_d = last_pix ? (mode_q ? B_SUM : DONE) : G_ADDR;
      end
      B_SUM: begin
        ph_d = ~ph;
        if (ph && last_in_blk) state_d = B_MEAN;
      end
      B_MEAN: state_d = B_DEV;
      B_DEV: begin
        ph_d = ~ph;
        if (ph && last_in_blk) state_d = B_VAR;
      end
      B_VAR: state_d = B_DLO;
      B_DLO: begin
        if (!ph) begin
          if (beta == BETA_W'(BLK_N)) state_d = B_DHI;
          else begin div_start = 1'b1; ph_d = 1'b1; end
        end else if (div_done) begin
          state_d = B_DHI;
          ph_d    = 1'b0;
        end
      end
      B_DHI: begin
        if (!ph) begin
          div_start = 1'b1;
          ph_d      = 1'b1;
        end else if (div_done) begin
          state_d = B_WR;
          ph_d    = 1'b0;
        end
      end
      B_WR: begin
        we_c = ph;
        ph_d = ~ph;
        if (ph && last_in_blk) state_d = B_NEXT;
      end
      B_NEXT: state_d = last_blk ? DONE : B_SUM;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_pix = '0;
    if (state == G_WR)
      out_pix = {{PIX_W{1'b0}}, g_gray, {PIX_W{1'b0}}};
    else if (state == B_WR && ph)
      out_pix = {{PIX_W{1'b0}}, (bitmap[idx] ? hm : lm), {PIX_W{1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row <= '0; col <= '0; mode_q <= 1'b0; busy <= 1'b0;
      gray_done <= 1'b0; compress_done <= 1'b0;
      sum <= '0; dev <= '0; p_val <= '0; beta <= '0; bitmap <= '0;
      avg <= '0; lm <= '0; hm <= '0;
    end else begin
      busy <= (state_d != IDLE) && (state_d != DONE);
      case (state)
        IDLE: if (start) begin
          row <= '0; col <= '0; mode_q <= mode_compress;
          gray_done <= 1'b0; compress_done <= 1'b0;
          sum <= '0; dev <= '0; beta <= '0;
        end
        // The full-image counter wraps to (0,0), which is block 0's origin.
        G_WR: begin
          {row, col} <= {row, col} + (2*ADDR_W)'(1);
          if (last_pix) gray_done <= 1'b1;
        end
        B_SUM: if (ph) begin
          sum <= sum + SUM_W'(g_in);
          {row[BLK_LOG2-1:0], col[BLK_LOG2-1:0]} <= idx + IDX_W'(1);
        end
        B_MEAN: avg <= PIX_W'(sum >> IDX_W);
        B_DEV: if (ph) begin
          dev         <= dev + SUM_W'(abs_d);
          bitmap[idx] <= hit;
          beta        <= beta + BETA_W'(hit);
          {row[BLK_LOG2-1:0], col[BLK_LOG2-1:0]} <= idx + IDX_W'(1);
        end
        B_VAR: p_val <= (dev >> IDX_W) << IDX_W;
        B_DLO: begin
          if (!ph && beta == BETA_W'(BLK_N)) lm <= avg;
          else if (ph && div_done) lm <= (div_q > P_W'(avg)) ? '0 : (avg - PIX_W'(div_q));
        end
        B_DHI: if (ph && div_done)
          hm <= (hm_sum > (P_W+1)'(PIX_MAX)) ? PIX_MAX : PIX_W'(hm_sum);
        B_WR: if (ph) {row[BLK_LOG2-1:0], col[BLK_LOG2-1:0]} <= idx + IDX_W'(1);
        B_NEXT: begin
          {row[ADDR_W-1:BLK_LOG2], col[ADDR_W-1:BLK_LOG2]} <=
            {row[ADDR_W-1:BLK_LOG2], col[ADDR_W-1:BLK_LOG2]} + (2*(ADDR_W-BLK_LOG2))'(1);
          sum <= '0; dev <= '0; beta <= '0;
          if (last_blk) compress_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ambtc_image_engine.sv
// Bench for ambtc_image_engine on an 8x8 image with 4x4 blocks; a synchronous
// RAM model feeds the DUT and every write is scored against a reference queue.
module tb_ambtc_image_engine;
  import ambtc_pkg::*;

  localparam int AW = 3, BL = 2, PW = 8, NPIX = 64, ENT_W = 2*AW + 3*PW;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode_compress = 1'b0;
  logic [3*PW-1:0] in_pix, out_pix;
  logic [AW-1:0]   row, col;
  logic            out_we, busy, gray_done, compress_done;
  ambtc_state_e    dbg_state;

  logic [3*PW-1:0] mem [NPIX];
  logic [ENT_W-1:0] exp_q[$];
  logic [ENT_W-1:0] mon_got, mon_want;
  int chk_cnt = 0, pass_cnt = 0, wr_count = 0, cyc = 0, last_we_cyc = 0;

  ambtc_image_engine #(.ADDR_W(AW), .BLK_LOG2(BL), .PIX_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_compress(mode_compress),
    .in_pix(in_pix), .row(row), .col(col), .out_we(out_we), .out_pix(out_pix),
    .busy(busy), .gray_done(gray_done), .compress_done(compress_done),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    in_pix <= mem[{row, col}];
    if (out_we) mem[{row, col}] = out_pix;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_we) begin
      wr_count++;
      last_we_cyc = cyc;
      chk_cnt++;
      mon_got = {row, col, out_pix};
      if (exp_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr=%0d pix=%06h, expected no write",
                 {row, col}, out_pix);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want)
          $display("FAIL write_%0d: got addr=%0d pix=%06h, expected addr=%0d pix=%06h",
                   wr_count, mon_got[ENT_W-1:3*PW], mon_got[3*PW-1:0],
                   mon_want[ENT_W-1:3*PW], mon_want[3*PW-1:0]);
        else pass_cnt++;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic int blk_addr(input int blk, input int k);
    return ((blk / 2) * 4 + k / 4) * 8 + (blk % 2) * 4 + k % 4;
  endfunction

  task automatic model_job(input bit cmp);
    int g[NPIX];
    int s, avg, d, beta, p, lm, hm, a, v, mx, mn, r_, g_, b_;
    for (int i = 0; i < NPIX; i++) begin
      r_ = int'(mem[i][23:16]); g_ = int'(mem[i][15:8]); b_ = int'(mem[i][7:0]);
      mx = r_; if (g_ > mx) mx = g_; if (b_ > mx) mx = b_;
      mn = r_; if (g_ < mn) mn = g_; if (b_ < mn) mn = b_;
      g[i] = (mx + mn) / 2;
      exp_q.push_back({AW'(i / 8), AW'(i % 8), 8'h00, PW'(g[i]), 8'h00});
    end
    if (cmp) begin
      for (int blk = 0; blk < 4; blk++) begin
        s = 0;
        for (int k = 0; k < 16; k++) s += g[blk_addr(blk, k)];
        avg = s / 16; d = 0; beta = 0;
        for (int k = 0; k < 16; k++) begin
          v = g[blk_addr(blk, k)];
          d += (v >= avg) ? v - avg : avg - v;
          if (v >= avg) beta++;
        end
        p = 16 * (d / 16);
        if (beta == 16) lm = avg;
        else begin
          lm = avg - p / (2 * (16 - beta));
          if (lm < 0) lm = 0;
        end
        hm = avg + p / (2 * beta);
        if (hm > 255) hm = 255;
        for (int k = 0; k < 16; k++) begin
          a = blk_addr(blk, k);
          v = g[a];
          exp_q.push_back({AW'(a / 8), AW'(a % 8), 8'h00, PW'((v >= avg) ? hm : lm), 8'h00});
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // kind: 0 random (pixel 0 fixed), 1 uniform block 0, 2 bimodal block 0, 3 clamp block 0
  task automatic load_image(input int kind);
    int a, v;
    for (int i = 0; i < NPIX; i++)
      mem[i] = {PW'($urandom_range(0, 255)), PW'($urandom_range(0, 255)), PW'($urandom_range(0, 255))};
    if (kind == 0) mem[0] = {8'd10, 8'd200, 8'd50};
    else begin
      for (int k = 0; k < 16; k++) begin
        a = (k / 4) * 8 + k % 4;
        if (kind == 1) v = 100;
        else if (kind == 2) v = ((k / 4 + k % 4) % 2) ? 200 : 0;
        else v = (k == 0) ? 0 : 255;
        mem[a] = {PW'(v), PW'(v), PW'(v)};
      end
    end
  endtask

  // glitch: pulse start with the opposite mode mid-run and leave mode flipped
  task automatic run_job(input bit mode, input bit glitch, output bit ok, output bit busy_seen);
    exp_q.delete();
    model_job(mode);
    wr_count = 0;
    ok = 1'b0;
    @(negedge clk); start = 1'b1; mode_compress = mode;
    @(negedge clk); start = 1'b0; busy_seen = busy;
    for (int i = 0; i < 3000; i++) begin
      if (glitch && i == 10) begin start = 1'b1; mode_compress = ~mode; end
      if (glitch && i == 11) start = 1'b0;
      @(negedge clk);
      if (mode ? compress_done : gray_done) begin ok = 1'b1; break; end
    end
  endtask

  function automatic int block0_bad(input int kind);
    int bad, a;
    logic [3*PW-1:0] want;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      a = (k / 4) * 8 + k % 4;
      if (kind == 1) want = 24'h006400;
      else if (kind == 2) want = ((k / 4 + k % 4) % 2) ? 24'h00C800 : 24'h000000;
      else want = (k == 0) ? 24'h000700 : 24'h00FE00;
      if (mem[a] !== want) bad++;
    end
    return bad;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({row, col, out_we, out_pix, busy, gray_done, compress_done} !== '0)
      $display("FAIL reset_outputs: got row=%0d col=%0d we=%b pix=%06h busy=%b gd=%b cd=%b, expected all 0",
               row, col, out_we, out_pix, busy, gray_done, compress_done);
    else pass_cnt++;
    chk_cnt++;
    if (dbg_state !== IDLE) $display("FAIL reset_state: got %0d, expected %0d", dbg_state, IDLE);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_gray;
    bit ok, bs;
    load_image(0);
    run_job(1'b0, 1'b0, ok, bs);
    chk_cnt++; if (!ok) $display("FAIL gray_timeout: got no gray_done, expected gray_done"); else pass_cnt++;
    chk_cnt++; if (bs !== 1'b1) $display("FAIL gray_busy_after_start: got %b, expected 1", bs); else pass_cnt++;
    chk_cnt++; if (cyc !== last_we_cyc + 1) $display("FAIL gray_done_timing: got cycle %0d, expected %0d", cyc, last_we_cyc + 1); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL gray_busy_fall: got %b, expected 0", busy); else pass_cnt++;
    chk_cnt++; if (dbg_state !== DONE) $display("FAIL gray_state: got %0d, expected %0d", dbg_state, DONE); else pass_cnt++;
    chk_cnt++; if (wr_count !== 64) $display("FAIL gray_writes: got %0d, expected 64", wr_count); else pass_cnt++;
    chk_cnt++; if (mem[0] !== 24'h006900) $display("FAIL gray_pix0: got %06h, expected 006900", mem[0]); else pass_cnt++;
    chk_cnt++; if (compress_done !== 1'b0) $display("FAIL gray_cd: got %b, expected 0", compress_done); else pass_cnt++;
  endtask

  task automatic test_start_in_done;
    bit ok, bs;
    load_image(0);
    run_job(1'b0, 1'b0, ok, bs);
    start = 1'b1; mode_compress = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_cnt++; if (dbg_state !== IDLE || busy !== 1'b0)
      $display("FAIL done_start_state: got state=%0d busy=%b, expected state=%0d busy=0", dbg_state, busy, IDLE);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++; if (dbg_state !== IDLE || gray_done !== 1'b1 || wr_count !== 64)
      $display("FAIL done_start_ignored: got state=%0d gd=%b writes=%0d, expected state=%0d gd=1 writes=64",
               dbg_state, gray_done, wr_count, IDLE);
    else pass_cnt++;
  endtask

  task automatic test_block(input int kind);
    bit ok, bs;
    int bad;
    load_image(kind);
    run_job(1'b1, 1'b0, ok, bs);
    chk_cnt++; if (!ok) $display("FAIL blk%0d_timeout: got no compress_done, expected compress_done", kind); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0 || gray_done !== 1'b1)
      $display("FAIL blk%0d_flags: got busy=%b gd=%b, expected busy=0 gd=1", kind, busy, gray_done);
    else pass_cnt++;
    chk_cnt++; if (wr_count !== 128 || exp_q.size() !== 0)
      $display("FAIL blk%0d_writes: got %0d writes %0d pending, expected 128 writes 0 pending", kind, wr_count, exp_q.size());
    else pass_cnt++;
    bad = block0_bad(kind);
    chk_cnt++; if (bad !== 0) $display("FAIL blk%0d_pixels: got %0d wrong pixels, expected 0", kind, bad); else pass_cnt++;
  endtask

  task automatic test_uniform;  test_block(1); endtask
  task automatic test_bimodal;  test_block(2); endtask
  task automatic test_clamp;    test_block(3); endtask

  task automatic test_reset_mid;
    bit found, ok, bs;
    int bad;
    load_image(3);
    exp_q.delete();
    model_job(1'b1);
    @(negedge clk); start = 1'b1; mode_compress = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (dbg_state == B_DEV) begin found = 1'b1; break; end
    end
    chk_cnt++; if (!found) $display("FAIL rstmid_reach_dev: got state=%0d, expected %0d", dbg_state, B_DEV); else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_cnt++;
    if ({row, col, out_we, out_pix, busy, gray_done, compress_done} !== '0 || dbg_state !== IDLE)
      $display("FAIL rstmid_outputs: got row=%0d col=%0d we=%b pix=%06h busy=%b gd=%b cd=%b state=%0d, expected all 0 and IDLE",
               row, col, out_we, out_pix, busy, gray_done, compress_done, dbg_state);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    exp_q.delete();
    load_image(2);
    run_job(1'b1, 1'b0, ok, bs);
    bad = block0_bad(2);
    chk_cnt++; if (!ok || wr_count !== 128 || exp_q.size() !== 0 || bad !== 0)
      $display("FAIL rstmid_rerun: got ok=%b writes=%0d pending=%0d bad=%0d, expected ok=1 writes=128 pending=0 bad=0",
               ok, wr_count, exp_q.size(), bad);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    bit ok, bs;
    load_image(0);
    run_job(1'b1, 1'b1, ok, bs);
    chk_cnt++; if (!ok || wr_count !== 128 || exp_q.size() !== 0)
      $display("FAIL busy_start_cmp: got ok=%b writes=%0d pending=%0d, expected ok=1 writes=128 pending=0", ok, wr_count, exp_q.size());
    else pass_cnt++;
    load_image(0);
    run_job(1'b0, 1'b1, ok, bs);
    chk_cnt++; if (!ok || wr_count !== 64 || exp_q.size() !== 0 || busy !== 1'b0)
      $display("FAIL busy_start_gray: got ok=%b writes=%0d pending=%0d busy=%b, expected ok=1 writes=64 pending=0 busy=0",
               ok, wr_count, exp_q.size(), busy);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    chk_cnt++; if (compress_done !== 1'b0 || wr_count !== 64)
      $display("FAIL busy_start_mode: got cd=%b writes=%0d, expected cd=0 writes=64", compress_done, wr_count);
    else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_gray;
    test_start_in_done;
    test_uniform;
    test_bimodal;
    test_clamp;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
